rv_mdu: RTL and testbench
=========================

# rv_mdu

Iterative, parametrised M-extension multiply/divide unit for the execute stage. Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation through a valid/ready handshake. Computes it bit-serially over Xlen cycles, with single-cycle fast paths for the RISC-V-defined divide corner cases. Returns the result with the destination-register tag. Supports pipeline flush (abort) at any point.

## Interface
- Xlen, 32, operand/result width; must be ≥ 8 and even.
- TagWidth, 5, width of the pass-through destination tag.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request (high only in IDLE).
- i_funct3  in  3  M-extension funct3 (OpF3MUL..OpF3REMU encodings).
- i_rs1  in  Xlen  operand 1 (multiplicand/dividend).
- i_rs2  in  Xlen  operand 2 (multiplier/divisor).
- i_tag  in  TagWidth  destination tag, returned unchanged.
- i_flush  in  1  abort any in-flight or pending-output operation.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_result  out  Xlen  result.
- o_tag  out  TagWidth  tag of the result.
- o_busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid & o_ready, latch funct3, tag, operand magnitudes and result sign flags.
  - For DIV/DIVU/REM/REMU with rs2=0, or DIV/REM with rs1=most-negative and rs2=all-ones, load the special result and go to DONE.
  - Otherwise clear the counter and go to CALC.
- CALC:
  - Process one bit per cycle for Xlen cycles.
  - Go to DONE when the counter reaches Xlen-1.
- DONE:
  - o_valid=1; o_result and o_tag are stable.
  - On i_ready, go to IDLE.
- Multiply:
  - Shift-add over a 2·Xlen-bit accumulator on unsigned magnitudes.
  - Negate the product when the sign flag is set.
  - Signedness: MUL and MULH treat both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned. MULHU treats both as unsigned.
  - MUL returns bits [Xlen-1:0]; the MULH variants return bits [2·Xlen-1:Xlen].
- Divide:
  - Restoring division on magnitudes, using an Xlen+1-bit partial remainder.
  - Signed quotient sign = sign(rs1) XOR sign(rs2); signed remainder sign = sign(rs1).
  - Unsigned variants apply no sign handling.
- Special divide results:
  - Divide by zero: quotient = all-ones (DIV and DIVU); remainder = rs1.
  - Signed overflow (DIV/REM with rs1=most-negative, rs2=all-ones): quotient = rs1; remainder = 0.
- Undefined funct3 values cannot occur (all 8 codes are valid).

## Timing
- Reset: state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_result=0, o_tag=0, counter=0.
- Accept on edge N:
  - Normal path: CALC during cycles N+1..N+Xlen; o_valid first high in cycle N+Xlen+1.
  - Special path: o_valid high in cycle N+1.
- o_valid holds with a stable result until an edge where i_ready=1.
- After that edge, o_ready=1 the next cycle. Back-to-back throughput is therefore one operation per Xlen+2 cycles.
- i_flush:
  - Takes priority over every other event on that edge and forces IDLE. o_valid=0 in the next cycle; no result is emitted.
  - i_flush together with an i_valid in IDLE does not accept the request.
  - i_flush in DONE together with i_ready: the result is treated as dropped.
- rst mid-operation behaves as i_flush, and additionally returns all outputs to their reset values.
- Operand inputs are sampled only on the accept edge; later changes are ignored.

## Structure
- funct3 encodings come from the shared ISA package's OpF3* constants; no new encodings are defined.
- Add mdu_state_e (IDLE, CALC, DONE) to the shared package.
- Natural sub-module: rv_mdu_iter, the one-bit-per-cycle datapath.
  - Inputs: mode (mul/div), step, load.
  - Holds the accumulator/remainder and the quotient shift registers.
- The top level owns the FSM, the sign pre/post-processing, the special cases and the handshake.

## Test plan
- MUL 7 × -3 (Xlen=32) → o_result 0xFFFFFFEB; o_valid exactly 33 cycles after accept; o_tag echoed.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU -1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD (-3). REM -7 / 2 → 0xFFFFFFFF (-1). DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF, and REM 5 / 0 → 5, each valid 1 cycle after accept. DIV 0x80000000 / -1 → 0x80000000 and REM of the same → 0.
- Hold i_ready=0 for 5 cycles in DONE → o_valid and o_result stable, o_ready=0. Then i_ready=1 → o_ready=1 the next cycle, and a back-to-back request is accepted.
- i_flush at CALC cycle 10, then a new request MUL 3 × 4 → no stale o_valid; result 12 after 33 cycles. Repeat with rst mid-CALC → all outputs at reset values.

Source files
------------

// File: rtl/rv_mdu_pkg.sv
// Shared definitions for the M-extension multiply/divide unit.
// Holds the RISC-V M-extension funct3 encodings (OpF3*) and the MDU FSM state type.
// Ports: none (package).
package rv_mdu_pkg;

    localparam logic [2:0] OpF3MUL    = 3'b000;
    localparam logic [2:0] OpF3MULH   = 3'b001;
    localparam logic [2:0] OpF3MULHSU = 3'b010;
    localparam logic [2:0] OpF3MULHU  = 3'b011;
    localparam logic [2:0] OpF3DIV    = 3'b100;
    localparam logic [2:0] OpF3DIVU   = 3'b101;
    localparam logic [2:0] OpF3REM    = 3'b110;
    localparam logic [2:0] OpF3REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/rv_mdu_iter.sv
// One-bit-per-cycle datapath of the multiply/divide unit, working on unsigned magnitudes.
// Multiply: shift-add on a 2*Xlen accumulator {partial product, multiplier}.
// Divide: restoring division with an Xlen+1-bit shifted partial remainder.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture operands and initialise the working registers
//   step            advance one iteration
//   mode            0 = multiply, 1 = divide
//   op_a, op_b      multiplicand/dividend and multiplier/divisor magnitudes
//   prod_next       product after the current step is applied
//   quot_next       quotient after the current step is applied
//   rem_next        remainder after the current step is applied
module rv_mdu_iter
    import rv_mdu_pkg::*;
#(
    parameter int Xlen = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic                mode,
    input  logic [Xlen-1:0]     op_a,
    input  logic [Xlen-1:0]     op_b,
    output logic [2*Xlen-1:0]   prod_next,
    output logic [Xlen-1:0]     quot_next,
    output logic [Xlen-1:0]     rem_next
);

    logic [Xlen-1:0]   mcand_r;
    logic [2*Xlen-1:0] acc_r;
    logic [Xlen-1:0]   divisor_r;
    logic [Xlen-1:0]   rem_r;
    logic [Xlen-1:0]   quot_r;

    logic [Xlen:0]     add_s;
    logic [2*Xlen-1:0] acc_step_s;
    logic [Xlen:0]     shift_s;
    logic              qbit_s;
    logic [Xlen-1:0]   rem_step_s;
    logic [Xlen-1:0]   quot_step_s;

    // Next-iteration values for both the multiply and divide recurrences.
    always_comb begin
        add_s = {1'b0, acc_r[2*Xlen-1:Xlen]};
        if (acc_r[0]) begin
            add_s = {1'b0, acc_r[2*Xlen-1:Xlen]} + {1'b0, mcand_r};
        end else begin
            add_s = {1'b0, acc_r[2*Xlen-1:Xlen]};
        end
        // Carry-out of the add lands in the top bit as the whole register shifts right.
        acc_step_s = {add_s, acc_r[Xlen-1:1]};

        // Dividend bits enter the remainder MSB-first from the quotient shift register.
        shift_s = {rem_r, quot_r[Xlen-1]};
        qbit_s  = (shift_s >= {1'b0, divisor_r});
        if (qbit_s) begin
            rem_step_s = Xlen'(shift_s - {1'b0, divisor_r});
        end else begin
            rem_step_s = shift_s[Xlen-1:0];
        end
        quot_step_s = {quot_r[Xlen-2:0], qbit_s};

        prod_next = acc_step_s;
        quot_next = quot_step_s;
        rem_next  = rem_step_s;
    end

    // Working registers: load on accept, advance one bit per step in the selected mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r   <= {Xlen{1'b0}};
            acc_r     <= {(2*Xlen){1'b0}};
            divisor_r <= {Xlen{1'b0}};
            rem_r     <= {Xlen{1'b0}};
            quot_r    <= {Xlen{1'b0}};
        end else if (load) begin
            mcand_r   <= op_a;
            acc_r     <= {{Xlen{1'b0}}, op_b};
            divisor_r <= op_b;
            rem_r     <= {Xlen{1'b0}};
            quot_r    <= op_a;
        end else if (step) begin
            if (mode) begin
                rem_r  <= rem_step_s;
                quot_r <= quot_step_s;
            end else begin
                acc_r  <= acc_step_s;
            end
        end
    end

endmodule

// File: rtl/rv_mdu.sv
// Iterative RISC-V M-extension multiply/divide unit.
// Owns the IDLE/CALC/DONE FSM, sign pre/post-processing, the divide corner cases
// (divide by zero, signed overflow) and the valid/ready handshakes.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_valid/o_ready       request handshake (o_ready only in IDLE)
//   i_funct3              M-extension operation
//   i_rs1, i_rs2          operands, sampled on the accept edge only
//   i_tag                 destination tag, echoed on o_tag
//   i_flush               abort in-flight or pending result, highest priority
//   o_valid/i_ready       result handshake
//   o_result, o_tag       result and its tag, stable while o_valid
//   o_busy                unit is not idle
module rv_mdu
    import rv_mdu_pkg::*;
#(
    parameter int Xlen     = 32,
    parameter int TagWidth = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [2:0]          i_funct3,
    input  logic [Xlen-1:0]     i_rs1,
    input  logic [Xlen-1:0]     i_rs2,
    input  logic [TagWidth-1:0] i_tag,
    input  logic                i_flush,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [Xlen-1:0]     o_result,
    output logic [TagWidth-1:0] o_tag,
    output logic                o_busy
);

    localparam int              CntW    = $clog2(Xlen);
    localparam logic [CntW-1:0] CntLast = CntW'(Xlen - 1);
    localparam logic [Xlen-1:0] MinNeg  = {1'b1, {(Xlen-1){1'b0}}};
    localparam logic [Xlen-1:0] AllOnes = {Xlen{1'b1}};

    mdu_state_e          state_r, state_nxt_s;
    logic [CntW-1:0]     cnt_r;
    logic [2:0]          f3_r;
    logic                neg_r;
    logic [Xlen-1:0]     result_r;
    logic [TagWidth-1:0] tag_r;

    logic                accept_s, step_s, finish_s;
    logic                sgn1_s, sgn2_s, neg_s;
    logic [Xlen-1:0]     mag1_s, mag2_s;
    logic                div0_s, ovf_s, special_s;
    logic [Xlen-1:0]     special_res_s;
    logic [2*Xlen-1:0]   prod_s, prod_fix_s;
    logic [Xlen-1:0]     quot_s, rem_s, quot_fix_s, rem_fix_s, final_s;

    // Request decode: operand signedness, magnitudes, result sign and corner cases.
    always_comb begin
        case (i_funct3)
            OpF3MUL, OpF3MULH, OpF3DIV, OpF3REM: begin
                sgn1_s = i_rs1[Xlen-1];
                sgn2_s = i_rs2[Xlen-1];
            end
            OpF3MULHSU: begin
                sgn1_s = i_rs1[Xlen-1];
                sgn2_s = 1'b0;
            end
            default: begin
                sgn1_s = 1'b0;
                sgn2_s = 1'b0;
            end
        endcase
        // Remainder takes the dividend's sign; everything else the XOR of both.
        if (i_funct3 == OpF3REM) begin
            neg_s = sgn1_s;
        end else begin
            neg_s = sgn1_s ^ sgn2_s;
        end
        mag1_s = sgn1_s ? ({Xlen{1'b0}} - i_rs1) : i_rs1;
        mag2_s = sgn2_s ? ({Xlen{1'b0}} - i_rs2) : i_rs2;

        div0_s    = i_funct3[2] && (i_rs2 == {Xlen{1'b0}});
        ovf_s     = ((i_funct3 == OpF3DIV) || (i_funct3 == OpF3REM)) &&
                    (i_rs1 == MinNeg) && (i_rs2 == AllOnes);
        special_s = div0_s || ovf_s;
        // funct3[1] separates the remainder forms from the quotient forms.
        if (div0_s) begin
            special_res_s = i_funct3[1] ? i_rs1 : AllOnes;
        end else if (ovf_s) begin
            special_res_s = i_funct3[1] ? {Xlen{1'b0}} : i_rs1;
        end else begin
            special_res_s = {Xlen{1'b0}};
        end
    end

    // Result post-processing from the datapath's final-step values.
    always_comb begin
        prod_fix_s = neg_r ? ({(2*Xlen){1'b0}} - prod_s) : prod_s;
        quot_fix_s = neg_r ? ({Xlen{1'b0}} - quot_s) : quot_s;
        rem_fix_s  = neg_r ? ({Xlen{1'b0}} - rem_s) : rem_s;
        case (f3_r)
            OpF3MUL:                           final_s = prod_fix_s[Xlen-1:0];
            OpF3MULH, OpF3MULHSU, OpF3MULHU:   final_s = prod_fix_s[2*Xlen-1:Xlen];
            OpF3DIV, OpF3DIVU:                 final_s = quot_fix_s;
            OpF3REM, OpF3REMU:                 final_s = rem_fix_s;
            default:                           final_s = {Xlen{1'b0}};
        endcase
    end

    // FSM next state; flush overrides every other event.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        step_s      = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_flush) begin
                    state_nxt_s = IDLE;
                end else if (i_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = special_s ? DONE : CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (i_flush) begin
                    state_nxt_s = IDLE;
                end else begin
                    step_s = 1'b1;
                    if (cnt_r == CntLast) begin
                        finish_s    = 1'b1;
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end
            end
            DONE: begin
                if (i_flush || i_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, counter, latched request fields and the registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= {CntW{1'b0}};
            f3_r     <= 3'b000;
            neg_r    <= 1'b0;
            result_r <= {Xlen{1'b0}};
            tag_r    <= {TagWidth{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                f3_r  <= i_funct3;
                neg_r <= neg_s;
                tag_r <= i_tag;
                cnt_r <= {CntW{1'b0}};
                if (special_s) begin
                    result_r <= special_res_s;
                end
            end else if (step_s) begin
                cnt_r <= cnt_r + CntW'(1);
                if (finish_s) begin
                    result_r <= final_s;
                end
            end
        end
    end

    rv_mdu_iter #(
        .Xlen (Xlen)
    ) u_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_s),
        .step      (step_s),
        .mode      (f3_r[2]),
        .op_a      (mag1_s),
        .op_b      (mag2_s),
        .prod_next (prod_s),
        .quot_next (quot_s),
        .rem_next  (rem_s)
    );

    assign o_ready  = (state_r == IDLE);
    assign o_valid  = (state_r == DONE);
    assign o_busy   = (state_r != IDLE);
    assign o_result = result_r;
    assign o_tag    = tag_r;

endmodule

// File: tb/tb_rv_mdu.sv
// Directed self-checking bench for rv_mdu (Xlen=32, TagWidth=5).
module tb_rv_mdu;
    import rv_mdu_pkg::*;

    localparam int Xlen     = 32;
    localparam int TagWidth = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_valid;
    logic                o_ready;
    logic [2:0]          i_funct3;
    logic [Xlen-1:0]     i_rs1;
    logic [Xlen-1:0]     i_rs2;
    logic [TagWidth-1:0] i_tag;
    logic                i_flush;
    logic                o_valid;
    logic                i_ready;
    logic [Xlen-1:0]     o_result;
    logic [TagWidth-1:0] o_tag;
    logic                o_busy;

    int n_assert = 0;
    int n_fail   = 0;

    rv_mdu #(.Xlen(Xlen), .TagWidth(TagWidth)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_funct3 (i_funct3),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_tag    (i_tag),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_tag    (o_tag),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge, then scramble the inputs.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t);
        int guard = 0;
        while (!o_ready && guard < 100) begin
            tick();
            guard++;
        end
        i_funct3 = f;
        i_rs1    = a;
        i_rs2    = b;
        i_tag    = t;
        i_valid  = 1'b1;
        tick();
        i_valid  = 1'b0;
        i_funct3 = 3'($urandom);
        i_rs1    = $urandom;
        i_rs2    = $urandom;
        i_tag    = 5'($urandom);
    endtask

    // Cycles from the accept edge until o_valid is seen (capped at 100).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!o_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        issue(f, a, b, t);
        wait_valid(lat);
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_res"}, 64'(o_result), 64'(exp_res));
        check({name, "_tag"}, 64'(o_tag), 64'(t));
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_funct3 = 3'b000;
        i_rs1    = 32'h0;
        i_rs2    = 32'h0;
        i_tag    = 5'h0;
        i_flush  = 1'b0;
        i_ready  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_ready",  64'(o_ready),  64'd1);
        check("rst_valid",  64'(o_valid),  64'd0);
        check("rst_busy",   64'(o_busy),   64'd0);
        check("rst_result", 64'(o_result), 64'd0);
        check("rst_tag",    64'(o_tag),    64'd0);

        // Multiply family
        issue(OpF3MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
        check("mul_busy", 64'(o_busy), 64'd1);
        check("mul_rdy",  64'(o_ready), 64'd0);
        wait_valid(lat);
        check("mul_lat", 64'(lat), 64'd33);
        check("mul_res", 64'(o_result), 64'hFFFF_FFEB);
        check("mul_tag", 64'(o_tag), 64'd5);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        run_op("mulh",   OpF3MULH,   32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 33);
        run_op("mulhu",  OpF3MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 33);
        run_op("mulhsu", OpF3MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33);

        // Divide family
        run_op("div",  OpF3DIV,  32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33);
        run_op("rem",  OpF3REM,  32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33);
        run_op("divu", OpF3DIVU, 32'd100,       32'd7, 5'd12, 32'd14,        33);
        run_op("remu", OpF3REMU, 32'd100,       32'd7, 5'd13, 32'd2,         33);

        // Corner cases return one cycle after accept
        run_op("divu0",   OpF3DIVU, 32'd5,         32'd0,         5'd20, 32'hFFFF_FFFF, 1);
        run_op("rem0",    OpF3REM,  32'd5,         32'd0,         5'd21, 32'd5,         1);
        run_op("div_ovf", OpF3DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, 1);
        run_op("rem_ovf", OpF3REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'd0,         1);

        // Result held while the consumer stalls, then back-to-back request
        issue(OpF3MUL, 32'd6, 32'd7, 5'd9);
        wait_valid(lat);
        check("hold_lat", 64'(lat), 64'd33);
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", 64'(o_valid),  64'd1);
            check("hold_res",   64'(o_result), 64'd42);
            check("hold_ready", 64'(o_ready),  64'd0);
            tick();
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("rel_ready", 64'(o_ready), 64'd1);
        check("rel_valid", 64'(o_valid), 64'd0);
        run_op("b2b", OpF3DIVU, 32'd100, 32'd7, 5'd14, 32'd14, 33);

        // Flush together with a request in IDLE: not accepted
        i_valid  = 1'b1;
        i_flush  = 1'b1;
        i_funct3 = OpF3MUL;
        tick();
        i_valid  = 1'b0;
        i_flush  = 1'b0;
        check("flush_idle_busy", 64'(o_busy), 64'd0);

        // Flush at CALC cycle 10
        issue(OpF3MUL, 32'd9, 32'd9, 5'd4);
        repeat (9) tick();
        check("pre_flush_busy", 64'(o_busy), 64'd1);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("flush_valid", 64'(o_valid), 64'd0);
        check("flush_busy",  64'(o_busy),  64'd0);
        check("flush_ready", 64'(o_ready), 64'd1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_valid) seen++;
            tick();
        end
        check("flush_stale", 64'(seen), 64'd0);
        run_op("post_flush", OpF3MUL, 32'd3, 32'd4, 5'd3, 32'd12, 33);

        // Flush in DONE together with i_ready drops the result
        issue(OpF3MUL, 32'd2, 32'd2, 5'd1);
        wait_valid(lat);
        check("fd_lat", 64'(lat), 64'd33);
        i_flush = 1'b1;
        i_ready = 1'b1;
        tick();
        i_flush = 1'b0;
        i_ready = 1'b0;
        check("fd_valid", 64'(o_valid), 64'd0);
        check("fd_ready", 64'(o_ready), 64'd1);

        // Reset mid-CALC
        issue(OpF3MUL, 32'd5, 32'd5, 5'd6);
        repeat (5) tick();
        check("pre_rst_busy", 64'(o_busy), 64'd1);
        check("pre_rst_res",  64'(o_result), 64'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_result", 64'(o_result), 64'd0);
        check("mrst_tag",    64'(o_tag),    64'd0);
        check("mrst_valid",  64'(o_valid),  64'd0);
        check("mrst_ready",  64'(o_ready),  64'd1);
        check("mrst_busy",   64'(o_busy),   64'd0);
        run_op("post_rst", OpF3MULHU, 32'h0001_0000, 32'h0003_0000, 5'd7, 32'd3, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
